te_decode: RTL and testbench



---
 rtl/te_decode.sv | 143 ++++++++++++++
 tb/tb_te_decode.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_decode.sv
`timescale 1ns/1ps
// te_decode: temporal-to-binary decoder for the te delay stage.
// Measures the cycle gap between a transition on tref and the following
// transition on tsig (either edge counts). The gap is returned as a
// BITS-wide value through a one-entry valid/ready output slot.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no measurement running; waiting for a tref transition
// MEAS  | measurement running; cnt holds cycles since the tref transition
module te_decode #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tref,
  input  logic            tsig,
  output logic [BITS-1:0] dout,
  output logic            valid,
  input  logic            ready,
  output logic            ovf,
  output logic            drop
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // cnt reaching 2^BITS means the measurable range has been exhausted
  localparam logic [BITS:0] CNT_MAX = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS:0] CNT_ONE = {{BITS{1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nxt;
  logic            tref_q;
  logic            tsig_q;
  logic            tref_e;
  logic            tsig_e;
  logic [BITS:0]   cnt;
  logic [BITS:0]   cnt_nxt;
  logic            res_vld;
  logic [BITS-1:0] res_val;
  logic            res_ovf;

  // Either polarity of transition is an event.
  assign tref_e = tref ^ tref_q;
  assign tsig_e = tsig ^ tsig_q;

  // Previous-sample registers for transition detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tref_q <= 1'b0;
      tsig_q <= 1'b0;
    end else begin
      tref_q <= tref;
      tsig_q <= tsig;
    end
  end

  // State and gap counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter update and result generation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_vld   = 1'b0;
    res_val   = '0;
    res_ovf   = 1'b0;
    case (state)
      IDLE: begin
        if (tref_e && tsig_e) begin
          // zero-delay transition: result 0, no measurement needed
          res_vld = 1'b1;
        end else if (tref_e) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = MEAS;
        end
        // a lone tsig transition here is spurious and ignored
      end
      MEAS: begin
        if (tsig_e) begin
          res_vld = 1'b1;
          res_val = cnt[BITS-1:0];
          if (tref_e) begin
            cnt_nxt = CNT_ONE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tref_e) begin
          // new reference before the delayed edge: abort as overflow, restart
          res_vld = 1'b1;
          res_val = '1;
          res_ovf = 1'b1;
          cnt_nxt = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          res_vld   = 1'b1;
          res_val   = '1;
          res_ovf   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-entry output slot; a full slot that is not being drained drops the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      drop  <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (res_vld) begin
        if (!valid || ready) begin
          dout  <= res_val;
          ovf   <= res_ovf;
          valid <= 1'b1;
        end else begin
          drop <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_te_decode.sv
`timescale 1ns/1ps
// Testbench for te_decode: directed scenarios plus randomized transactions,
// with a cycle-indexed reference model feeding a result scoreboard.
module tb_te_decode;
  localparam int BITS = 4;
  localparam int RANGE = 1 << BITS;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tref = 1'b0;
  logic            tsig = 1'b0;
  logic            ready = 1'b1;
  logic [BITS-1:0] dout;
  logic            valid;
  logic            ovf;
  logic            drop;

  te_decode #(.BITS(BITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .tref  (tref),
    .tsig  (tsig),
    .dout  (dout),
    .valid (valid),
    .ready (ready),
    .ovf   (ovf),
    .drop  (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BITS-1:0] val;
    logic            ov;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   drop_exp = 0;
  int   drop_seen = 0;

  // reference model state: cycle index of the pending tref transition (-1 = none)
  int   cyc = 0;
  int   start = -1;
  logic m_prev_tref = 1'b0;
  logic m_prev_tsig = 1'b0;
  bit   m_full = 1'b0;

  bit   rdy_rand = 1'b0;
  logic rdy_fix = 1'b1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_result(logic [BITS-1:0] v, logic o, logic rd);
    res_t r;
    if (!m_full || rd) begin
      r.val = v;
      r.ov  = o;
      exp_q.push_back(r);
      m_full = 1'b1;
    end else begin
      drop_exp++;
    end
  endfunction

  // Evaluates the rising edge that will sample (tr, ts, rd).
  function automatic void model_edge(logic tr, logic ts, logic rd);
    bit              te;
    bit              se;
    bit              got;
    logic [BITS-1:0] v;
    logic            o;
    int              age;
    te  = (tr != m_prev_tref);
    se  = (ts != m_prev_tsig);
    got = 1'b0;
    v   = '0;
    o   = 1'b0;
    m_prev_tref = tr;
    m_prev_tsig = ts;
    if (start >= 0) begin
      age = cyc - start;
      if (se) begin
        got = 1'b1;
        v   = age[BITS-1:0];
        start = te ? cyc : -1;
      end else if (te) begin
        got = 1'b1;
        v   = '1;
        o   = 1'b1;
        start = cyc;
      end else if (age == RANGE) begin
        got = 1'b1;
        v   = '1;
        o   = 1'b1;
        start = -1;
      end
    end else if (te && se) begin
      got = 1'b1;
    end else if (te) begin
      start = cyc;
    end
    if (got) model_result(v, o, rd);
    else if (m_full && rd) m_full = 1'b0;
    cyc++;
  endfunction

  // Called at posedge+1: drive inputs for the next edge, then advance past it.
  task automatic step(bit ttr, bit tts);
    logic rd;
    rd = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fix;
    if (ttr) tref = ~tref;
    if (tts) tsig = ~tsig;
    ready = rd;
    model_edge(tref, tsig, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  // tref transition followed k cycles later by tsig transition
  task automatic meas(int k);
    if (k == 0) begin
      step(1'b1, 1'b1);
    end else begin
      step(1'b1, 1'b0);
      idle(k - 1);
      step(1'b0, 1'b1);
    end
  endtask

  task automatic do_reset(bit keep_lines);
    #2;
    rst = 1'b1;
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    start = -1;
    m_prev_tref = 1'b0;
    m_prev_tsig = 1'b0;
    m_full = 1'b0;
    exp_q.delete();
    if (!keep_lines) begin
      tref = 1'b0;
      tsig = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: handshake decided at the next edge is visible at the negedge.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (drop === 1'b1) drop_seen++;
        if (valid === 1'b1 && ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got dout=%0h ovf=%0b, none expected", dout, ovf);
          end else begin
            r = exp_q.pop_front();
            check("sb_dout", 32'(dout), 32'(r.val));
            check("sb_ovf", 32'(ovf), 32'(r.ov));
          end
        end
      end
    end
  end

  initial begin
    int d0;
    int kind;
    int a;
    int b;
    @(posedge clk);
    #1;
    do_reset(1'b0);
    idle(5);
    check("idle_valid", 32'(valid), 32'd0);

    // sweep both polarities: the timeout in between flips tref parity
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < RANGE; k++) begin
        meas(k);
        idle((k == 0) ? RANGE : RANGE - k);
      end
      if (pass == 0) begin
        step(1'b1, 1'b0);
        idle(RANGE + 2);
      end
    end

    // simultaneous edges
    step(1'b1, 1'b1);
    check("simul_valid", 32'(valid), 32'd1);
    check("simul_dout", 32'(dout), 32'd0);
    idle(2);

    // timeout and late tsig
    step(1'b1, 1'b0);
    idle(RANGE - 1);
    check("to_early", 32'(valid), 32'd0);
    idle(1);
    check("to_valid", 32'(valid), 32'd1);
    check("to_ovf", 32'(ovf), 32'd1);
    check("to_dout", 32'(dout), 32'hf);
    idle(2);
    step(1'b0, 1'b1);
    idle(2);
    check("late_tsig", 32'(valid), 32'd0);

    // backpressure: 3 held, 5 dropped
    rdy_fix = 1'b0;
    d0 = drop_seen;
    meas(3);
    meas(5);
    idle(2);
    check("bp_dout", 32'(dout), 32'd3);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_drop", 32'(drop_seen - d0), 32'd1);
    rdy_fix = 1'b1;
    step(1'b0, 1'b0);
    check("bp_clear", 32'(valid), 32'd0);
    idle(2);

    // abort/restart: tref at 0 and 4, tsig at 6
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1);
    check("abort_dout", 32'(dout), 32'd2);
    check("abort_ovf", 32'(ovf), 32'd0);
    idle(3);

    // reset during measurement emits nothing
    step(1'b1, 1'b0);
    idle(3);
    do_reset(1'b0);
    idle(RANGE + 4);
    check("rst_meas", 32'(valid), 32'd0);

    // high tref held through reset registers as a transition afterwards
    step(1'b1, 1'b0);
    do_reset(1'b1);
    step(1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1);
    check("post_rst_dout", 32'(dout), 32'd2);
    check("post_rst_valid", 32'(valid), 32'd1);
    idle(3);

    // randomized transactions with random backpressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        meas($urandom_range(0, RANGE - 1));
      end else if (kind == 5) begin
        step(1'b1, 1'b0);
        idle(RANGE + $urandom_range(0, 2));
        step(1'b0, 1'b1);
      end else if (kind == 6) begin
        a = $urandom_range(1, RANGE - 1);
        b = $urandom_range(1, RANGE - 1);
        step(1'b1, 1'b0);
        idle(a - 1);
        step(1'b1, 1'b0);
        idle(b - 1);
        step(1'b0, 1'b1);
      end else if (kind == 7) begin
        a = $urandom_range(1, RANGE - 1);
        b = $urandom_range(1, RANGE - 1);
        step(1'b1, 1'b0);
        idle(a - 1);
        step(1'b1, 1'b1);
        idle(b - 1);
        step(1'b0, 1'b1);
      end else begin
        step(1'b0, 1'b1);
      end
      idle($urandom_range(0, 3));
    end

    rdy_rand = 1'b0;
    rdy_fix = 1'b1;
    idle(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("drop_total", 32'(drop_seen), 32'(drop_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
